// File: rtl/seg_display_sched.sv
// Two-requester 8-digit seven-segment display scheduler: round-robin intake,
// double-dabble binary-to-BCD conversion, committed buffer and multiplexed scan.
module seg_display_sched #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [26:0] req0_value,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [26:0] req1_value,
  output logic        req1_ready,
  input  logic        blank_lz,
  output logic        busy,
  output logic [7:0]  CA,
  output logic [7:0]  AN
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t      r_state;
  logic        r_pref0;
  logic        r_busy;
  logic [26:0] r_bin;
  logic [35:0] r_bcd;
  logic [4:0]  r_cnt;
  logic [7:0]  r_buf [0:7];

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [7:0]    r_ca;
  logic [7:0]    r_an;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_idle;
  logic        w_ovf;
  logic [35:0] w_adj;
  logic [7:0]  w_pat [0:7];

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h98;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  // r_pref0 high means req0 wins a tie (it was not the last one granted).
  assign w_grant0   = req0_valid && (!req1_valid || r_pref0);
  assign w_grant1   = req1_valid && (!req0_valid || !r_pref0);
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;
  assign busy       = r_busy;
  assign CA         = r_ca;
  assign AN         = r_an;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? r_bcd[gi*4 +: 4] + 4'd3
                                                           : r_bcd[gi*4 +: 4];
    end
  endgenerate

  assign w_ovf = (r_bcd[35:32] != 4'd0);

  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      logic w_blank;
      if (gi == 0) begin : g_lsd
        assign w_blank = 1'b0;
      end else begin : g_upper
        // Blank only when this digit and everything above it is zero.
        assign w_blank = blank_lz && (r_bcd[31:gi*4] == '0);
      end
      assign w_pat[gi] = w_ovf   ? 8'h86 :
                         w_blank ? 8'hFF : seg7(r_bcd[gi*4 +: 4]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pref0 <= 1'b1;
      r_busy  <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < 8; i++) r_buf[i] <= 8'hFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0_ready || req1_ready) begin
            r_bin   <= req0_ready ? req0_value : req1_value;
            r_pref0 <= req1_ready;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 5'd1;
          if (r_cnt == 5'd26) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          for (int i = 0; i < 8; i++) r_buf[i] <= w_pat[i];
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Scan runs free of the FSM; CA/AN only move at terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_ca    <= 8'hFF;
      r_an    <= 8'hFF;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
      r_an    <= ~(8'h01 << r_idx);
      r_ca    <= r_buf[r_idx];
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

endmodule
